// File: rtl/wave_frame_seq.sv
// wave_frame_seq: walks the 64-entry wave ROM and streams frames to the FFT.
// Emits START/ED strobes, with optional inter-frame gaps, HOLD stall and ABORT.
module wave_frame_seq #(
  parameter int WIDTH   = 16,
  parameter int NFRAMES = 1,
  parameter int GAP     = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             GO,
  input  logic             SEL_REF,
  input  logic             HOLD,
  input  logic             ABORT,
  output logic [5:0]       ROM_ADDR,
  input  logic [WIDTH-1:0] ROM_RE,
  input  logic [WIDTH-1:0] ROM_IM,
  input  logic [WIDTH-1:0] ROM_REF,
  output logic             START,
  output logic             ED,
  output logic [WIDTH-1:0] DR,
  output logic [WIDTH-1:0] DI,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      FRAME_CNT
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [15:0] NF = 16'(NFRAMES);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    STRT,
    STRM,
    GAPW
  } state_t;

  state_t state;
  state_t state_d;

  logic [5:0]       addr_d;
  logic             start_d;
  logic             ed_d;
  logic [WIDTH-1:0] dr_d;
  logic [WIDTH-1:0] di_d;
  logic             busy_d;
  logic             done_d;
  logic [15:0]      fcnt_d;
  logic [15:0]      fcnt_inc;
  logic             sel_q;
  logic             sel_d;
  logic [GW-1:0]    gcnt_q;
  logic [GW-1:0]    gcnt_d;

  assign fcnt_inc = FRAME_CNT + 16'd1;

  // Next state and next register values; ABORT overrides everything else.
  always_comb begin
    state_d = state;
    addr_d  = ROM_ADDR;
    start_d = 1'b0;
    ed_d    = 1'b0;
    dr_d    = DR;
    di_d    = DI;
    busy_d  = BUSY;
    done_d  = 1'b0;
    fcnt_d  = FRAME_CNT;
    sel_d   = sel_q;
    gcnt_d  = gcnt_q;
    unique case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (GO && !ABORT && !BUSY) begin
          state_d = STRT;
          sel_d   = SEL_REF;
          fcnt_d  = '0;
          busy_d  = 1'b1;
          addr_d  = '0;
          start_d = 1'b1;
        end
      end
      STRT, STRM: begin
        state_d = STRM;
        if (!HOLD) begin
          dr_d   = sel_q ? ROM_REF : ROM_RE;
          di_d   = sel_q ? '0 : ROM_IM;
          ed_d   = 1'b1;
          addr_d = ROM_ADDR + 6'd1;
          if (ROM_ADDR == 6'd63) begin
            fcnt_d = fcnt_inc;
            if (NF != 16'd0 && fcnt_inc == NF) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (GAP > 0) begin
              state_d = GAPW;
              gcnt_d  = '0;
            end
          end
        end
      end
      GAPW: begin
        if (gcnt_q == GLAST) begin
          state_d = STRM;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (ABORT && state != IDLE) begin
      state_d = IDLE;
      addr_d  = ROM_ADDR;
      dr_d    = DR;
      di_d    = DI;
      start_d = 1'b0;
      ed_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      fcnt_d  = FRAME_CNT;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Registered outputs and datapath state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ROM_ADDR  <= '0;
      START     <= 1'b0;
      ED        <= 1'b0;
      DR        <= '0;
      DI        <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      FRAME_CNT <= '0;
      sel_q     <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      ROM_ADDR  <= addr_d;
      START     <= start_d;
      ED        <= ed_d;
      DR        <= dr_d;
      DI        <= di_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
      FRAME_CNT <= fcnt_d;
      sel_q     <= sel_d;
      gcnt_q    <= gcnt_d;
    end
  end

endmodule

// File: tb/tb_wave_frame_seq.sv
// tb_wave_frame_seq: directed checks of wave_frame_seq in three configurations.
// Single frame, multi-frame with gaps, and continuous mode with ABORT.
module tb_wave_frame_seq;

  logic clk = 1'b0;
  logic rst, hold, abort, sel;
  logic go_a, go_b, go_c;

  logic [5:0]  addr_a, addr_b, addr_c;
  logic [15:0] re_a, im_a, rf_a, re_b, im_b, rf_b, re_c, im_c, rf_c;
  logic        start_a, ed_a, busy_a, done_a;
  logic        start_b, ed_b, busy_b, done_b;
  logic        start_c, ed_c, busy_c, done_c;
  logic [15:0] dr_a, di_a, fcnt_a;
  logic [15:0] dr_b, di_b, fcnt_b;
  logic [15:0] dr_c, di_c, fcnt_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] re_w(input logic [5:0] a);
    return {4'hA, 6'd0, a};
  endfunction

  function automatic logic [15:0] im_w(input logic [5:0] a);
    return {4'h5, a, 6'd0};
  endfunction

  function automatic logic [15:0] rf_w(input logic [5:0] a);
    return (a == 6'd1 || a == 6'd3 || a == 6'd5 || a == 6'd7) ? 16'h7FFC : 16'h0000;
  endfunction

  assign re_a = re_w(addr_a);
  assign im_a = im_w(addr_a);
  assign rf_a = rf_w(addr_a);
  assign re_b = re_w(addr_b);
  assign im_b = im_w(addr_b);
  assign rf_b = rf_w(addr_b);
  assign re_c = re_w(addr_c);
  assign im_c = im_w(addr_c);
  assign rf_c = rf_w(addr_c);

  wave_frame_seq #(.WIDTH(16), .NFRAMES(1), .GAP(0)) u_a (
    .CLK(clk), .RST(rst), .GO(go_a), .SEL_REF(sel), .HOLD(hold),
    .ABORT(abort), .ROM_ADDR(addr_a), .ROM_RE(re_a), .ROM_IM(im_a),
    .ROM_REF(rf_a), .START(start_a), .ED(ed_a), .DR(dr_a), .DI(di_a),
    .BUSY(busy_a), .DONE(done_a), .FRAME_CNT(fcnt_a)
  );

  wave_frame_seq #(.WIDTH(16), .NFRAMES(3), .GAP(2)) u_b (
    .CLK(clk), .RST(rst), .GO(go_b), .SEL_REF(sel), .HOLD(hold),
    .ABORT(abort), .ROM_ADDR(addr_b), .ROM_RE(re_b), .ROM_IM(im_b),
    .ROM_REF(rf_b), .START(start_b), .ED(ed_b), .DR(dr_b), .DI(di_b),
    .BUSY(busy_b), .DONE(done_b), .FRAME_CNT(fcnt_b)
  );

  wave_frame_seq #(.WIDTH(16), .NFRAMES(0), .GAP(0)) u_c (
    .CLK(clk), .RST(rst), .GO(go_c), .SEL_REF(sel), .HOLD(hold),
    .ABORT(abort), .ROM_ADDR(addr_c), .ROM_RE(re_c), .ROM_IM(im_c),
    .ROM_REF(rf_c), .START(start_c), .ED(ed_c), .DR(dr_c), .DI(di_c),
    .BUSY(busy_c), .DONE(done_c), .FRAME_CNT(fcnt_c)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; hold = 1'b0; abort = 1'b0; sel = 1'b0;
    go_a = 1'b0; go_b = 1'b0; go_c = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst ctl", {start_a, ed_a, busy_a, done_a}, 4'b0000);
    chk("rst addr", addr_a, 6'd0);
    chk("rst data", {dr_a, di_a}, 32'd0);
    chk("rst fcnt", fcnt_a, 16'd0);
    tick();

    // single frame, cos/sin
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    chk("t1 start", {start_a, ed_a, busy_a}, 3'b101);
    chk("t1 addr0", addr_a, 6'd0);
    for (int i = 0; i < 64; i++) begin
      tick();
      chk("t1 ctl", {ed_a, done_a, start_a, busy_a}, {1'b1, i == 63, 1'b0, 1'b1});
      chk("t1 dr", dr_a, re_w(6'(i)));
      chk("t1 di", di_a, im_w(6'(i)));
    end
    tick();
    chk("t1 end", {ed_a, done_a, busy_a}, 3'b000);
    chk("t1 fcnt", fcnt_a, 16'd1);
    tick();

    // reference table; SEL_REF changes mid-frame are ignored
    sel = 1'b1;
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    chk("t2 start", start_a, 1'b1);
    for (int i = 0; i < 64; i++) begin
      tick();
      if (i == 30) sel = 1'b0;
      chk("t2 ed", {ed_a, done_a}, {1'b1, i == 63});
      chk("t2 dr", dr_a,
          (i == 1 || i == 3 || i == 5 || i == 7) ? 16'h7FFC : 16'h0000);
      chk("t2 di", di_a, 16'h0000);
    end
    sel = 1'b0;
    tick();
    tick();

    // HOLD for 3 cycles while address 10 is presented
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    for (int c = 2; c <= 68; c++) begin
      int idx;
      logic ede;
      tick();
      hold = (c >= 11 && c <= 13);
      ede = !(c >= 12 && c <= 14);
      idx = (c < 12) ? c - 2 : c - 5;
      chk("t3 ctl", {ed_a, done_a}, {ede, c == 68});
      if (ede) chk("t3 dr", dr_a, re_w(6'(idx)));
    end
    hold = 1'b0;
    tick();
    chk("t3 end", {busy_a, ed_a}, 2'b00);
    chk("t3 fcnt", fcnt_a, 16'd1);
    tick();

    // GO while busy ignored, then RST mid-frame
    go_a = 1'b1;
    tick();
    go_a = 1'b0;
    for (int c = 2; c <= 22; c++) begin
      tick();
      go_a = (c == 5);
      chk("t6 ctl", {ed_a, start_a, busy_a}, 3'b101);
      chk("t6 dr", dr_a, re_w(6'(c - 2)));
      if (c == 22) rst = 1'b1;
    end
    go_a = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6 rst ctl", {start_a, ed_a, busy_a, done_a}, 4'b0000);
    chk("t6 rst addr", addr_a, 6'd0);
    chk("t6 rst data", {dr_a, di_a}, 32'd0);
    chk("t6 rst fcnt", fcnt_a, 16'd0);
    tick();

    // three frames with 2-cycle gaps
    go_b = 1'b1;
    tick();
    go_b = 1'b0;
    chk("t4 start", {start_b, busy_b}, 2'b11);
    for (int c = 2; c <= 198; c++) begin
      int r;
      logic ede;
      tick();
      r = (c - 2) % 66;
      ede = (r < 64) && (c <= 197);
      chk("t4 ctl", {ed_b, done_b, start_b, busy_b},
          {ede, c == 197, 1'b0, c <= 197});
      if (ede) chk("t4 dr", dr_b, re_w(6'(r)));
    end
    chk("t4 fcnt", fcnt_b, 16'd3);
    tick();

    // continuous mode, ABORT at sample 40 of the second frame
    go_c = 1'b1;
    tick();
    go_c = 1'b0;
    chk("t5 start", start_c, 1'b1);
    for (int c = 2; c <= 106; c++) begin
      tick();
      if (c == 106) abort = 1'b1;
      chk("t5 ctl", {ed_c, done_c, start_c}, 3'b100);
      chk("t5 dr", dr_c, re_w(6'((c - 2) % 64)));
    end
    tick();
    abort = 1'b0;
    chk("t5 abort", {ed_c, busy_c, done_c, start_c}, 4'b0000);
    chk("t5 fcnt", fcnt_c, 16'd1);
    go_c = 1'b1;
    abort = 1'b1;
    tick();
    go_c = 1'b0;
    abort = 1'b0;
    chk("t5 go+abort", {busy_c, start_c}, 2'b00);
    go_c = 1'b1;
    tick();
    go_c = 1'b0;
    chk("t5 restart", {start_c, busy_c}, 2'b11);
    chk("t5 addr0", addr_c, 6'd0);
    chk("t5 fcnt0", fcnt_c, 16'd0);
    tick();
    chk("t5 first ed", ed_c, 1'b1);
    chk("t5 first dr", dr_c, re_w(6'd0));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5 stop", busy_c, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
